// File: rtl/jt89_gg_wrseq.sv
`default_nettype none
// =============================================================================
// Module  : jt89_gg_wrseq
// Purpose : Two-requester write arbiter and FIFO. It replays PSG writes as timed
//           wr_n strobes and applies Game Gear pan writes in order with them.
// Option  : JT89_WRSEQ_MUTE_EN adds a mute input that injects a 4-write mute burst.
// Rev     : 1.0  initial release
// =============================================================================
module jt89_gg_wrseq #(
    parameter int DEPTH   = 4,
    parameter int LOW_CYC = 2,
    parameter int GAP_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       req_a,
    input  logic [7:0] dat_a,
    input  logic       pan_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] dat_b,
    input  logic       pan_b,
    output logic       ack_b,
`ifdef JT89_WRSEQ_MUTE_EN
    input  logic       mute,
`endif
    output logic       psg_wr_n,
    output logic [7:0] psg_din,
    output logic [7:0] pan,
    output logic       full,
    output logic       busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LOW_CYC > GAP_CYC) ? $clog2(LOW_CYC + 1) : $clog2(GAP_CYC + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_STROBE = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          last_b;
    logic          push, pop;
    logic [8:0]    push_data, head;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          burst_go;
    logic [7:0]    burst_byte;

    // Tie-break favours whoever was not granted last; full blocks pushes even on a pop cycle.
    assign full      = (count == (AW+1)'(DEPTH));
    assign ack_a     = req_a & ~full & (~req_b | last_b);
    assign ack_b     = req_b & ~full & (~req_a | ~last_b);
    assign push      = ack_a | ack_b;
    assign push_data = ack_a ? {pan_a, dat_a} : {pan_b, dat_b};
    assign head      = mem[rd_ptr];
    assign pop       = clk_en & (state == S_IDLE) & (count != '0) & ~burst_go;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_b <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ack_a)      last_b <= 1'b0;
            else if (ack_b) last_b <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            psg_wr_n <= 1'b1;
            psg_din  <= 8'h00;
            pan      <= 8'hFF;
        end else if (clk_en) begin
            case (state)
                S_IDLE: begin
                    if (burst_go) begin
                        psg_din <= burst_byte;
                        state   <= S_SETUP;
                    end else if (count != '0) begin
                        if (head[8]) begin
                            pan <= head[7:0];
                        end else begin
                            psg_din <= head[7:0];
                            state   <= S_SETUP;
                        end
                    end
                end
                S_SETUP: begin
                    psg_wr_n <= 1'b0;
                    cnt      <= '0;
                    state    <= S_STROBE;
                end
                S_STROBE: begin
                    if (cnt == CW'(LOW_CYC - 1)) begin
                        psg_wr_n <= 1'b1;
                        cnt      <= '0;
                        state    <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == CW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef JT89_WRSEQ_MUTE_EN
    logic       mute_d, armed, bursting;
    logic [1:0] bidx;

    // Burst writes max attenuation to channels 0..3: 9F, BF, DF, FF.
    assign burst_go   = (state == S_IDLE) & (armed | bursting);
    assign burst_byte = {1'b1, bidx, 5'h1F};
    assign busy       = (count != '0) | (state != S_IDLE) | armed | bursting;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mute_d   <= 1'b0;
            armed    <= 1'b0;
            bursting <= 1'b0;
            bidx     <= 2'd0;
        end else begin
            mute_d <= mute;
            if (clk_en && burst_go) begin
                bidx     <= bidx + 1'b1;
                bursting <= (bidx != 2'd3);
            end
            // A new edge wins over consumption so an edge on the start tick queues another burst.
            if (mute & ~mute_d)
                armed <= 1'b1;
            else if (clk_en && burst_go && !bursting)
                armed <= 1'b0;
        end
    end
`else
    assign burst_go   = 1'b0;
    assign burst_byte = 8'h00;
    assign busy       = (count != '0) | (state != S_IDLE);
`endif

endmodule
`default_nettype wire
